// File: rtl/rdma_rd_rsp_tag_checker_if.sv
// Handshake bundle for the RDMA read-response tag checker: request metadata,
// the tagged user response stream and the untagged network response stream.
interface rdma_rd_rsp_tag_checker_if #(
  parameter int DATA_BITS  = 512,
  parameter int TID_BITS   = 6,
  parameter int TDEST_BITS = 16,
  parameter int LEN_BITS   = 28
);
  // Request metadata forwarded from the network side.
  logic                    s_req_valid;
  logic                    s_req_ready;
  logic [TID_BITS-1:0]     s_req_vfid;
  logic [TDEST_BITS-1:0]   s_req_route;
  logic [LEN_BITS-1:0]     s_req_len;

  // Tagged response from the user.
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [DATA_BITS-1:0]    s_axis_tdata;
  logic [DATA_BITS/8-1:0]  s_axis_tkeep;
  logic                    s_axis_tlast;
  logic [TID_BITS-1:0]     s_axis_tid;
  logic [TDEST_BITS-1:0]   s_axis_tdest;

  // Untagged response toward the network.
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [DATA_BITS-1:0]    m_axis_tdata;
  logic [DATA_BITS/8-1:0]  m_axis_tkeep;
  logic                    m_axis_tlast;

  // Checker view: consumes requests and the tagged stream, produces the plain stream.
  modport slave (
    input  s_req_valid, s_req_vfid, s_req_route, s_req_len,
    output s_req_ready,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    input  m_axis_tready
  );

  // Environment view: the opposite direction of every signal.
  modport master (
    output s_req_valid, s_req_vfid, s_req_route, s_req_len,
    input  s_req_ready,
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/rdma_rd_rsp_tag_checker.sv
// RDMA read-response tag checker. Matches each user response packet against the
// oldest outstanding read request (tid = vfid, tdest = route), enforces the
// requested byte length, strips the tags and forwards a plain stream. Packets
// with wrong tags and bytes beyond the requested length are discarded.
module rdma_rd_rsp_tag_checker #(
  parameter int DATA_BITS  = 512,
  parameter int TID_BITS   = 6,
  parameter int TDEST_BITS = 16,
  parameter int LEN_BITS   = 28,
  parameter int Q_DEPTH    = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  rdma_rd_rsp_tag_checker_if.slave bus,
  output logic                    err_mismatch,
  output logic                    err_short,
  output logic                    err_long,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             err_cnt
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int PTR_BITS  = $clog2(Q_DEPTH);
  localparam int CNT_W     = PTR_BITS + 1;
  localparam int NB_W      = $clog2(KEEP_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Number of valid bytes in a beat.
  function automatic logic [NB_W-1:0] popcount(input logic [KEEP_BITS-1:0] keep);
    logic [NB_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < KEEP_BITS; i++) begin
      acc = acc + NB_W'(keep[i]);
    end
    return acc;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Request FIFO
  logic [TID_BITS-1:0]   fifo_vfid  [Q_DEPTH];
  logic [TDEST_BITS-1:0] fifo_route [Q_DEPTH];
  logic [LEN_BITS-1:0]   fifo_len   [Q_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  live_q;
  logic                  fifo_full, fifo_empty, push, pop;

  // Checker state
  state_t                state_q, state_d;
  logic [TID_BITS-1:0]   cur_vfid_q;
  logic [TDEST_BITS-1:0] cur_route_q;
  logic [LEN_BITS-1:0]   rem_q;
  logic                  err_mm_q, err_short_q, err_long_q;
  logic [31:0]           pkt_cnt_q, err_cnt_q;

  // Output register
  logic                  out_vld_q, out_last_q;
  logic [DATA_BITS-1:0]  out_data_q;
  logic [KEEP_BITS-1:0]  out_keep_q;

  // Beat decode
  logic                  out_free, accept, tag_ok, reach;
  logic [NB_W-1:0]       nb;
  logic                  fwd_beat, fwd_last;
  logic                  ev_mm, ev_short, ev_long, ev_pkt;

  assign fifo_full  = (cnt_q == CNT_W'(Q_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // A request is only taken into the checker while it sits in IDLE.
  assign pop        = (state_q == IDLE) && !fifo_empty;
  // A full FIFO still accepts a push in a cycle that also pops.
  assign bus.s_req_ready = live_q && (!fifo_full || pop);
  assign push       = bus.s_req_valid && bus.s_req_ready;

  assign out_free   = !out_vld_q || bus.m_axis_tready;
  assign bus.s_axis_tready = (state_q != IDLE) && out_free;
  assign accept     = bus.s_axis_tvalid && bus.s_axis_tready;
  assign tag_ok     = (bus.s_axis_tid == cur_vfid_q) && (bus.s_axis_tdest == cur_route_q);
  assign nb         = popcount(bus.s_axis_tkeep);
  assign reach      = (LEN_BITS'(nb) >= rem_q);

  assign bus.m_axis_tvalid = out_vld_q;
  assign bus.m_axis_tdata  = out_data_q;
  assign bus.m_axis_tkeep  = out_keep_q;
  assign bus.m_axis_tlast  = out_last_q;

  assign err_mismatch = err_mm_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign err_cnt      = err_cnt_q;

  // Ready stays low for the first cycle after reset release.
  always_ff @(posedge aclk) begin
    if (areset) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // FIFO storage: written at the tail on push, no reset needed.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_vfid[wr_ptr_q]  <= bus.s_req_vfid;
      fifo_route[wr_ptr_q] <= bus.s_req_route;
      fifo_len[wr_ptr_q]   <= bus.s_req_len;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at Q_DEPTH.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Per-beat decision: next state, whether the beat is forwarded, and events.
  always_comb begin
    state_d  = state_q;
    fwd_beat = 1'b0;
    fwd_last = 1'b0;
    ev_mm    = 1'b0;
    ev_short = 1'b0;
    ev_long  = 1'b0;
    ev_pkt   = 1'b0;
    case (state_q)
      IDLE: begin
        // Zero-length requests expect no data and are retired on the spot.
        if (pop) state_d = (fifo_len[rd_ptr_q] == '0) ? IDLE : CHECK;
      end
      CHECK, PASS: begin
        if (accept) begin
          if ((state_q == CHECK) && !tag_ok) begin
            ev_mm   = 1'b1;
            state_d = bus.s_axis_tlast ? IDLE : DRAIN;
          end else begin
            fwd_beat = 1'b1;
            if (reach) begin
              fwd_last = 1'b1;
              ev_pkt   = 1'b1;
              if (!bus.s_axis_tlast) begin
                ev_long = 1'b1;
                state_d = DRAIN;
              end else begin
                state_d = IDLE;
              end
            end else if (bus.s_axis_tlast) begin
              fwd_last = 1'b1;
              ev_short = 1'b1;
              ev_pkt   = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = PASS;
            end
          end
        end
      end
      DRAIN: begin
        if (accept && bus.s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Checker FSM, remaining-length tracking, error pulses and counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      err_mm_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      if (pop)                       rem_q <= fifo_len[rd_ptr_q];
      else if (fwd_beat && !fwd_last) rem_q <= rem_q - LEN_BITS'(nb);
      err_mm_q    <= ev_mm;
      err_short_q <= ev_short;
      err_long_q  <= ev_long;
      if (ev_pkt)                        pkt_cnt_q <= sat_inc(pkt_cnt_q);
      if (ev_mm || ev_short || ev_long)  err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  // Expected tags of the packet in flight, captured on pop.
  always_ff @(posedge aclk) begin
    if (pop) begin
      cur_vfid_q  <= fifo_vfid[rd_ptr_q];
      cur_route_q <= fifo_route[rd_ptr_q];
    end
  end

  // Output register valid/last: loads a forwarded beat, empties on downstream take.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else if (fwd_beat) begin
      out_vld_q  <= 1'b1;
      out_last_q <= fwd_last;
    end else if (bus.m_axis_tready) begin
      out_vld_q  <= 1'b0;
    end
  end

  // Output register payload, passed through unchanged.
  always_ff @(posedge aclk) begin
    if (fwd_beat) begin
      out_data_q <= bus.s_axis_tdata;
      out_keep_q <= bus.s_axis_tkeep;
    end
  end

endmodule

// File: tb/tb_rdma_rd_rsp_tag_checker.sv
// Directed scoreboard bench for rdma_rd_rsp_tag_checker.
module tb_rdma_rd_rsp_tag_checker;

  localparam int DB = 512;
  localparam int KB = DB / 8;

  typedef struct packed {
    logic [DB-1:0] d;
    logic [KB-1:0] k;
    logic          l;
  } beat_t;

  localparam logic [KB-1:0] K_FULL = {KB{1'b1}};
  localparam logic [KB-1:0] K_36   = 64'h0000_000F_FFFF_FFFF;

  logic        aclk;
  logic        areset;
  logic        err_mismatch, err_short, err_long;
  logic [31:0] pkt_cnt, err_cnt;

  rdma_rd_rsp_tag_checker_if #(.DATA_BITS(DB), .TID_BITS(6), .TDEST_BITS(16), .LEN_BITS(28)) bus ();

  rdma_rd_rsp_tag_checker #(
    .DATA_BITS(DB), .TID_BITS(6), .TDEST_BITS(16), .LEN_BITS(28), .Q_DEPTH(8)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .bus          (bus),
    .err_mismatch (err_mismatch),
    .err_short    (err_short),
    .err_long     (err_long),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  int    seen_mm = 0, seen_short = 0, seen_long = 0;
  logic  tog_en = 1'b0;
  logic  mrdy_cfg = 1'b1;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DB-1:0] mk(input int n);
    logic [DB-1:0] r;
    for (int i = 0; i < DB / 32; i++) r[i*32 +: 32] = 32'(n * 256 + i) ^ 32'hC0DE_0000;
    return r;
  endfunction

  function automatic beat_t eb(input logic [DB-1:0] d, input logic [KB-1:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    return b;
  endfunction

  // Output monitor: pops the scoreboard on every transfer and tallies error pulses.
  always @(negedge aclk) begin
    if (err_mismatch) seen_mm++;
    if (err_short)    seen_short++;
    if (err_long)     seen_long++;
    if (!areset && bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got data %0h last %0b, expected none", bus.m_axis_tdata, bus.m_axis_tlast);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_data", bus.m_axis_tdata, e.d);
        chk("out_keep", DB'(bus.m_axis_tkeep), DB'(e.k));
        chk("out_last", DB'(bus.m_axis_tlast), DB'(e.l));
      end
    end
  end

  // Downstream ready: either a fixed level or toggling every cycle.
  initial begin
    logic ph;
    ph = 1'b0;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      ph = !ph;
      bus.m_axis_tready = tog_en ? ph : mrdy_cfg;
    end
  end

  task automatic push_req(input logic [5:0] v, input logic [15:0] r, input logic [27:0] len);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    bus.s_req_valid = 1'b1;
    bus.s_req_vfid  = v;
    bus.s_req_route = r;
    bus.s_req_len   = len;
    while (!got && n < 200) begin
      @(negedge aclk);
      got = bus.s_req_ready;
      @(posedge aclk);
      #1;
      n++;
    end
    bus.s_req_valid = 1'b0;
    if (!got) chk("req_timeout", DB'(got), DB'(1));
  endtask

  task automatic send_beat(input logic [DB-1:0] d, input logic [KB-1:0] k, input logic l,
                           input logic [5:0] tid, input logic [15:0] tdest);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    bus.s_axis_tid    = tid;
    bus.s_axis_tdest  = tdest;
    while (!got && n < 200) begin
      @(negedge aclk);
      got = bus.s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    bus.s_axis_tvalid = 1'b0;
    if (!got) chk("beat_timeout", DB'(got), DB'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge aclk);
      n++;
    end
    chk("drain_left", DB'(exp_q.size()), DB'(0));
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic chk_stat(input string tag, input int pk, input int er, input int mm, input int sh, input int lg);
    @(negedge aclk);
    chk({tag, "_pkt_cnt"}, DB'(pkt_cnt), DB'(pk));
    chk({tag, "_err_cnt"}, DB'(err_cnt), DB'(er));
    chk({tag, "_mm_pulses"}, DB'(seen_mm), DB'(mm));
    chk({tag, "_short_pulses"}, DB'(seen_short), DB'(sh));
    chk({tag, "_long_pulses"}, DB'(seen_long), DB'(lg));
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy_seen;
    areset = 1'b1;
    bus.s_req_valid = 1'b0; bus.s_req_vfid = '0; bus.s_req_route = '0; bus.s_req_len = '0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
    bus.s_axis_tlast = 1'b0; bus.s_axis_tid = '0; bus.s_axis_tdest = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", DB'(bus.m_axis_tvalid), DB'(0));
    chk("rst_s_tready", DB'(bus.s_axis_tready), DB'(0));
    chk("rst_req_ready", DB'(bus.s_req_ready), DB'(0));
    chk("rst_pkt_cnt", DB'(pkt_cnt), DB'(0));
    chk("rst_err_cnt", DB'(err_cnt), DB'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // 3 matching full beats, len 192.
    push_req(6'd3, 16'h0102, 28'd192);
    exp_q.push_back(eb(mk(1), K_FULL, 1'b0));
    exp_q.push_back(eb(mk(2), K_FULL, 1'b0));
    exp_q.push_back(eb(mk(3), K_FULL, 1'b1));
    chk("t1_idle_tvalid", DB'(bus.m_axis_tvalid), DB'(0));
    send_beat(mk(1), K_FULL, 1'b0, 6'd3, 16'h0102);
    chk("t1_latency_tvalid", DB'(bus.m_axis_tvalid), DB'(1));
    send_beat(mk(2), K_FULL, 1'b0, 6'd3, 16'h0102);
    send_beat(mk(3), K_FULL, 1'b1, 6'd3, 16'h0102);
    wait_drain();
    chk_stat("t1", 1, 0, 0, 0, 0);

    // Wrong tid dropped, next request's packet passes.
    push_req(6'd3, 16'h0102, 28'd192);
    push_req(6'd7, 16'h0304, 28'd128);
    send_beat(mk(10), K_FULL, 1'b0, 6'd5, 16'h0102);
    send_beat(mk(11), K_FULL, 1'b1, 6'd5, 16'h0102);
    exp_q.push_back(eb(mk(12), K_FULL, 1'b0));
    exp_q.push_back(eb(mk(13), K_FULL, 1'b1));
    send_beat(mk(12), K_FULL, 1'b0, 6'd7, 16'h0304);
    send_beat(mk(13), K_FULL, 1'b1, 6'd7, 16'h0304);
    wait_drain();
    chk_stat("t2", 2, 1, 1, 0, 0);

    // len 100: 64 + 36 bytes reaches length with tlast still low.
    push_req(6'd1, 16'h0011, 28'd100);
    exp_q.push_back(eb(mk(20), K_FULL, 1'b0));
    exp_q.push_back(eb(mk(21), K_36, 1'b1));
    send_beat(mk(20), K_FULL, 1'b0, 6'd1, 16'h0011);
    send_beat(mk(21), K_36, 1'b0, 6'd1, 16'h0011);
    send_beat(mk(22), K_FULL, 1'b1, 6'd1, 16'h0011);
    wait_drain();
    chk_stat("t3", 3, 2, 1, 0, 1);

    // len 256 but packet ends after 128 bytes.
    push_req(6'd2, 16'h0022, 28'd256);
    exp_q.push_back(eb(mk(30), K_FULL, 1'b0));
    exp_q.push_back(eb(mk(31), K_FULL, 1'b1));
    send_beat(mk(30), K_FULL, 1'b0, 6'd2, 16'h0022);
    send_beat(mk(31), K_FULL, 1'b1, 6'd2, 16'h0022);
    wait_drain();
    chk_stat("t4", 4, 3, 1, 1, 1);

    // Zero-length request is retired silently; the following one is served.
    push_req(6'd4, 16'h0044, 28'd0);
    push_req(6'd4, 16'h0044, 28'd64);
    exp_q.push_back(eb(mk(40), K_FULL, 1'b1));
    send_beat(mk(40), K_FULL, 1'b1, 6'd4, 16'h0044);
    wait_drain();
    chk_stat("t4b", 5, 3, 1, 1, 1);

    // Fill: one request moves into the checker, eight more fill the FIFO.
    for (int i = 0; i < 9; i++) push_req(6'(10 + i), 16'h0500 + 16'(i), 28'd64);
    bus.s_req_valid = 1'b1;
    bus.s_req_vfid  = 6'd63;
    bus.s_req_route = 16'hFFFF;
    bus.s_req_len   = 28'd64;
    rdy_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      rdy_seen = rdy_seen | bus.s_req_ready;
      @(posedge aclk);
      #1;
    end
    bus.s_req_valid = 1'b0;
    chk("t5_full_stall", DB'(rdy_seen), DB'(0));
    tog_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(eb(mk(50 + i), K_FULL, 1'b1));
      send_beat(mk(50 + i), K_FULL, 1'b1, 6'(10 + i), 16'h0500 + 16'(i));
    end
    wait_drain();
    tog_en = 1'b0;
    mrdy_cfg = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk_stat("t5", 14, 3, 1, 1, 1);

    // Reset in the middle of a packet; the held output beat is lost.
    mrdy_cfg = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    push_req(6'd9, 16'h0900, 28'd192);
    send_beat(mk(60), K_FULL, 1'b0, 6'd9, 16'h0900);
    areset = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = mk(61);
    bus.s_axis_tkeep  = K_FULL;
    bus.s_axis_tlast  = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("t6_m_tvalid", DB'(bus.m_axis_tvalid), DB'(0));
    chk("t6_s_tready", DB'(bus.s_axis_tready), DB'(0));
    chk("t6_req_ready", DB'(bus.s_req_ready), DB'(0));
    chk("t6_pkt_cnt", DB'(pkt_cnt), DB'(0));
    chk("t6_err_cnt", DB'(err_cnt), DB'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    mrdy_cfg = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      rdy_seen = rdy_seen | bus.s_axis_tready | bus.m_axis_tvalid;
      @(posedge aclk);
      #1;
    end
    bus.s_axis_tvalid = 1'b0;
    chk("t6_stall_no_req", DB'(rdy_seen), DB'(0));
    push_req(6'd9, 16'h0900, 28'd64);
    exp_q.push_back(eb(mk(62), K_FULL, 1'b1));
    send_beat(mk(62), K_FULL, 1'b1, 6'd9, 16'h0900);
    wait_drain();
    chk_stat("t6", 1, 0, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
